// File: rtl/tlb_op_ctrl.sv
// rtl/tlb_op_ctrl.sv - TLB maintenance op sequencer with Random/Wired registers
//
// Purpose: accepts one TLBP/TLBR/TLBWI/TLBWR at a time from the MEM stage,
// presents the op to the combinational TLB for exactly one cycle, captures the
// TLB results and then pulses the matching CP0 write enable. Owns the Random
// and Wired registers and supplies the latched Random as the TLBWR slot.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid, req_op        op request from MEM (001 P, 010 R, 011 WI, 100 WR)
//   req_ready, flush, stall  handshake / pipeline control
//   done, refetch            completion pulse, refetch request (TLBWI/TLBWR)
//   tlb_type, tlb_random     op and write slot to the TLB array
//   tlb_*_in                 combinational TLB results
//   cp0_index_we/_wdata      Index writeback after TLBP
//   cp0_tlbr_we, cp0_*_wdata EntryHi/PageMask/EntryLo0/EntryLo1 writeback after TLBR
//   wired_we, wired_wdata    CP0 write to Wired
//   random_o, wired_o        current Random and Wired

module tlb_op_ctrl #(
    parameter int TLB_LINE  = 32,
    parameter int TLB_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic [2:0]           req_op,
    output logic                 req_ready,
    input  logic                 flush,
    output logic                 stall,
    output logic                 done,
    output logic                 refetch,
    output logic [2:0]           tlb_type,
    output logic [31:0]          tlb_random,
    input  logic [31:0]          tlb_index_in,
    input  logic [31:0]          tlb_entryhi_in,
    input  logic [31:0]          tlb_pagemask_in,
    input  logic [31:0]          tlb_entrylo0_in,
    input  logic [31:0]          tlb_entrylo1_in,
    output logic                 cp0_index_we,
    output logic [31:0]          cp0_index_wdata,
    output logic                 cp0_tlbr_we,
    output logic [31:0]          cp0_entryhi_wdata,
    output logic [31:0]          cp0_pagemask_wdata,
    output logic [31:0]          cp0_entrylo0_wdata,
    output logic [31:0]          cp0_entrylo1_wdata,
    input  logic                 wired_we,
    input  logic [TLB_WIDTH-1:0] wired_wdata,
    output logic [TLB_WIDTH-1:0] random_o,
    output logic [TLB_WIDTH-1:0] wired_o
);

    localparam logic [2:0] OP_TLBP  = 3'b001;
    localparam logic [2:0] OP_TLBR  = 3'b010;
    localparam logic [2:0] OP_TLBWI = 3'b011;
    localparam logic [2:0] OP_TLBWR = 3'b100;

    localparam logic [TLB_WIDTH-1:0] RND_MAX = TLB_WIDTH'(TLB_LINE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t state, state_next;

    logic [2:0]           op_q;
    logic [TLB_WIDTH-1:0] rnd_q;
    logic [31:0]          idx_q;
    logic [31:0]          entryhi_q;
    logic [31:0]          pagemask_q;
    logic [31:0]          entrylo0_q;
    logic [31:0]          entrylo1_q;
    logic [TLB_WIDTH-1:0] random_q;
    logic [TLB_WIDTH-1:0] wired_q;

    logic op_valid;
    logic accept;

    always_comb begin
        op_valid = 1'b0;
        case (req_op)
            OP_TLBP, OP_TLBR, OP_TLBWI, OP_TLBWR: op_valid = 1'b1;
            default:                              op_valid = 1'b0;
        endcase
    end

    assign accept = (state == S_IDLE) && req_valid && !flush && op_valid;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush only matters at acceptance, an accepted op runs to completion
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (accept) state_next = S_ISSUE;
            S_ISSUE:  state_next = S_COMMIT;
            S_COMMIT: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Op latch and TLB result capture; results are sampled on the edge closing ISSUE
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= 3'b000;
            rnd_q      <= '0;
            idx_q      <= 32'h0;
            entryhi_q  <= 32'h0;
            pagemask_q <= 32'h0;
            entrylo0_q <= 32'h0;
            entrylo1_q <= 32'h0;
        end else begin
            if (accept) begin
                op_q  <= req_op;
                rnd_q <= random_q;
            end
            if (state == S_ISSUE) begin
                if (op_q == OP_TLBP) begin
                    idx_q <= tlb_index_in;
                end
                if (op_q == OP_TLBR) begin
                    entryhi_q  <= tlb_entryhi_in;
                    pagemask_q <= tlb_pagemask_in;
                    entrylo0_q <= tlb_entrylo0_in;
                    entrylo1_q <= tlb_entrylo1_in;
                end
            end
        end
    end

    // Random counts down to Wired and wraps to the top; a Wired write restarts it at the top
    always_ff @(posedge clk) begin
        if (rst) begin
            random_q <= RND_MAX;
            wired_q  <= '0;
        end else if (wired_we) begin
            wired_q  <= wired_wdata;
            random_q <= RND_MAX;
        end else if (random_q == wired_q) begin
            random_q <= RND_MAX;
        end else begin
            random_q <= random_q - 1'b1;
        end
    end

    // Output logic; rst forces the idle values at once so an aborted op never
    // reaches the TLB or CP0 in the reset cycle
    always_comb begin
        req_ready    = 1'b0;
        stall        = 1'b0;
        done         = 1'b0;
        refetch      = 1'b0;
        tlb_type     = 3'b000;
        tlb_random   = 32'h0;
        cp0_index_we = 1'b0;
        cp0_tlbr_we  = 1'b0;
        if (rst) begin
            req_ready = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    req_ready = 1'b1;
                    stall     = accept;
                end
                S_ISSUE: begin
                    stall      = 1'b1;
                    tlb_type   = op_q;
                    tlb_random = {{(32 - TLB_WIDTH){1'b0}}, rnd_q};
                end
                S_COMMIT: begin
                    done         = 1'b1;
                    cp0_index_we = (op_q == OP_TLBP);
                    cp0_tlbr_we  = (op_q == OP_TLBR);
                    refetch      = (op_q == OP_TLBWI) || (op_q == OP_TLBWR);
                end
                default: begin
                    req_ready = 1'b0;
                end
            endcase
        end
    end

    assign cp0_index_wdata    = idx_q;
    assign cp0_entryhi_wdata  = entryhi_q;
    assign cp0_pagemask_wdata = pagemask_q;
    assign cp0_entrylo0_wdata = entrylo0_q;
    assign cp0_entrylo1_wdata = entrylo1_q;
    assign random_o           = random_q;
    assign wired_o            = wired_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb/tb_tlb_op_ctrl.sv - directed self-checking bench for tlb_op_ctrl

module tb_tlb_op_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [2:0]  req_op;
    logic        req_ready;
    logic        flush;
    logic        stall;
    logic        done;
    logic        refetch;
    logic [2:0]  tlb_type;
    logic [31:0] tlb_random;
    logic [31:0] tlb_index_in;
    logic [31:0] tlb_entryhi_in;
    logic [31:0] tlb_pagemask_in;
    logic [31:0] tlb_entrylo0_in;
    logic [31:0] tlb_entrylo1_in;
    logic        cp0_index_we;
    logic [31:0] cp0_index_wdata;
    logic        cp0_tlbr_we;
    logic [31:0] cp0_entryhi_wdata;
    logic [31:0] cp0_pagemask_wdata;
    logic [31:0] cp0_entrylo0_wdata;
    logic [31:0] cp0_entrylo1_wdata;
    logic        wired_we;
    logic [4:0]  wired_wdata;
    logic [4:0]  random_o;
    logic [4:0]  wired_o;

    int checks = 0;
    int errors = 0;

    logic [4:0] rnd_m;
    logic [4:0] wired_m;

    tlb_op_ctrl #(.TLB_LINE(32), .TLB_WIDTH(5)) dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid          (req_valid),
        .req_op             (req_op),
        .req_ready          (req_ready),
        .flush              (flush),
        .stall              (stall),
        .done               (done),
        .refetch            (refetch),
        .tlb_type           (tlb_type),
        .tlb_random         (tlb_random),
        .tlb_index_in       (tlb_index_in),
        .tlb_entryhi_in     (tlb_entryhi_in),
        .tlb_pagemask_in    (tlb_pagemask_in),
        .tlb_entrylo0_in    (tlb_entrylo0_in),
        .tlb_entrylo1_in    (tlb_entrylo1_in),
        .cp0_index_we       (cp0_index_we),
        .cp0_index_wdata    (cp0_index_wdata),
        .cp0_tlbr_we        (cp0_tlbr_we),
        .cp0_entryhi_wdata  (cp0_entryhi_wdata),
        .cp0_pagemask_wdata (cp0_pagemask_wdata),
        .cp0_entrylo0_wdata (cp0_entrylo0_wdata),
        .cp0_entrylo1_wdata (cp0_entrylo1_wdata),
        .wired_we           (wired_we),
        .wired_wdata        (wired_wdata),
        .random_o           (random_o),
        .wired_o            (wired_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; the Random/Wired model follows the inputs seen at that edge
    task automatic tick();
        if (rst) begin
            rnd_m   = 5'd31;
            wired_m = 5'd0;
        end else if (wired_we) begin
            wired_m = wired_wdata;
            rnd_m   = 5'd31;
        end else if (rnd_m == wired_m) begin
            rnd_m = 5'd31;
        end else begin
            rnd_m = rnd_m - 5'd1;
        end
        @(posedge clk);
        #1;
    endtask

    // One op from acceptance at T through T+3; wwe/fl are applied during T+1
    task automatic run_op(input logic [2:0] op, input logic [31:0] idx,
                          input logic [31:0] eh, input logic [31:0] pm,
                          input logic [31:0] lo0, input logic [31:0] lo1,
                          input logic wwe, input logic fl);
        logic [4:0] rnd_at_accept;
        req_valid = 1'b1;
        req_op    = op;
        #1;
        rnd_at_accept = rnd_m;
        check("t0_stall", {31'd0, stall}, 32'd1);
        check("t0_ready", {31'd0, req_ready}, 32'd1);
        check("t0_type", {29'd0, tlb_type}, 32'd0);
        tick();
        req_valid       = 1'b0;
        req_op          = 3'd0;
        tlb_index_in    = idx;
        tlb_entryhi_in  = eh;
        tlb_pagemask_in = pm;
        tlb_entrylo0_in = lo0;
        tlb_entrylo1_in = lo1;
        wired_we        = wwe;
        wired_wdata     = 5'd0;
        flush           = fl;
        #1;
        check("t1_type", {29'd0, tlb_type}, {29'd0, op});
        check("t1_stall", {31'd0, stall}, 32'd1);
        check("t1_ready", {31'd0, req_ready}, 32'd0);
        check("t1_done", {31'd0, done}, 32'd0);
        if (op == 3'b100) check("t1_random", tlb_random, {27'd0, rnd_at_accept});
        tick();
        wired_we        = 1'b0;
        flush           = 1'b0;
        tlb_index_in    = 32'hdead_beef;
        tlb_entryhi_in  = 32'hdead_beef;
        tlb_pagemask_in = 32'hdead_beef;
        tlb_entrylo0_in = 32'hdead_beef;
        tlb_entrylo1_in = 32'hdead_beef;
        #1;
        check("t2_done", {31'd0, done}, 32'd1);
        check("t2_stall", {31'd0, stall}, 32'd0);
        check("t2_type", {29'd0, tlb_type}, 32'd0);
        check("t2_index_we", {31'd0, cp0_index_we}, {31'd0, op == 3'b001});
        check("t2_tlbr_we", {31'd0, cp0_tlbr_we}, {31'd0, op == 3'b010});
        check("t2_refetch", {31'd0, refetch}, {31'd0, op == 3'b011 || op == 3'b100});
        if (op == 3'b001) check("t2_index_wdata", cp0_index_wdata, idx);
        if (op == 3'b010) begin
            check("t2_entryhi", cp0_entryhi_wdata, eh);
            check("t2_pagemask", cp0_pagemask_wdata, pm);
            check("t2_entrylo0", cp0_entrylo0_wdata, lo0);
            check("t2_entrylo1", cp0_entrylo1_wdata, lo1);
        end
        tick();
        #1;
        check("t3_done", {31'd0, done}, 32'd0);
        check("t3_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        rst             = 1'b1;
        req_valid       = 1'b0;
        req_op          = 3'd0;
        flush           = 1'b0;
        tlb_index_in    = 32'h0;
        tlb_entryhi_in  = 32'h0;
        tlb_pagemask_in = 32'h0;
        tlb_entrylo0_in = 32'h0;
        tlb_entrylo1_in = 32'h0;
        wired_we        = 1'b0;
        wired_wdata     = 5'd0;
        rnd_m           = 5'd31;
        wired_m         = 5'd0;
        #2;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset values
        check("rst_random", {27'd0, random_o}, 32'd31);
        check("rst_wired", {27'd0, wired_o}, 32'd0);
        check("rst_type", {29'd0, tlb_type}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_refetch", {31'd0, refetch}, 32'd0);
        check("rst_index_we", {31'd0, cp0_index_we}, 32'd0);
        check("rst_tlbr_we", {31'd0, cp0_tlbr_we}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_index_wdata", cp0_index_wdata, 32'd0);
        check("rst_entryhi", cp0_entryhi_wdata, 32'd0);

        // Free-running Random with Wired = 0: 31 - (k mod 32)
        for (int k = 1; k <= 40; k++) begin
            tick();
            #1;
            check("rnd_w0", {27'd0, random_o}, 32'(31 - (k % 32)));
        end
        // After 40 ticks Random = 23; 20 more reach 3
        for (int k = 0; k < 20; k++) tick();
        #1;
        check("rnd_at3", {27'd0, random_o}, 32'd3);

        // Wired write restarts Random at 31; then 31 - (j mod 24), floor 8
        wired_we    = 1'b1;
        wired_wdata = 5'd8;
        tick();
        wired_we = 1'b0;
        #1;
        check("wired_set", {27'd0, wired_o}, 32'd8);
        check("wired_rnd31", {27'd0, random_o}, 32'd31);
        for (int j = 1; j <= 30; j++) begin
            tick();
            #1;
            check("rnd_w8", {27'd0, random_o}, 32'(31 - (j % 24)));
            if (random_o < 5'd8) check("rnd_floor", {27'd0, random_o}, 32'd8);
        end

        // TLBP twice
        run_op(3'b001, 32'h0000_0005, 0, 0, 0, 0, 1'b0, 1'b0);
        run_op(3'b001, 32'h8000_0000, 0, 0, 0, 0, 1'b0, 1'b0);
        // TLBR
        run_op(3'b010, 32'h0, 32'h1234_5000, 32'h0000_6000, 32'h0000_0217, 32'h0000_0257, 1'b0, 1'b0);

        // TLBWR accepted at Random = 20, Wired rewritten to 0 at T+1
        begin
            int budget = 64;
            while (rnd_m != 5'd20 && budget > 0) begin
                tick();
                budget--;
            end
            #1;
            check("wr_rnd20", {27'd0, random_o}, 32'd20);
        end
        run_op(3'b100, 0, 0, 0, 0, 0, 1'b1, 1'b0);
        check("wr_wired0", {27'd0, wired_o}, 32'd0);

        // TLBWI with flush during ISSUE still completes
        run_op(3'b011, 0, 0, 0, 0, 0, 1'b0, 1'b1);

        // req_valid with flush in IDLE is dropped
        req_valid = 1'b1;
        req_op    = 3'b011;
        flush     = 1'b1;
        #1;
        check("flush_stall", {31'd0, stall}, 32'd0);
        tick();
        req_valid = 1'b0;
        flush     = 1'b0;
        #1;
        check("flush_type", {29'd0, tlb_type}, 32'd0);
        check("flush_ready", {31'd0, req_ready}, 32'd1);

        // Invalid op code is dropped
        req_valid = 1'b1;
        req_op    = 3'b101;
        #1;
        check("noop_stall", {31'd0, stall}, 32'd0);
        tick();
        req_valid = 1'b0;
        req_op    = 3'd0;
        #1;
        check("noop_type", {29'd0, tlb_type}, 32'd0);
        check("noop_ready", {31'd0, req_ready}, 32'd1);

        // rst during ISSUE aborts the TLBR
        req_valid      = 1'b1;
        req_op         = 3'b010;
        tick();
        req_valid      = 1'b0;
        req_op         = 3'd0;
        rst            = 1'b1;
        tlb_entryhi_in = 32'hcafe_0000;
        #1;
        check("abort_type", {29'd0, tlb_type}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("abort_done2", {31'd0, done}, 32'd0);
        check("abort_tlbr_we", {31'd0, cp0_tlbr_we}, 32'd0);
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        check("abort_hold", cp0_entryhi_wdata, 32'd0);
        check("abort_random", {27'd0, random_o}, 32'd31);
        tick();
        #1;
        check("abort_done3", {31'd0, done}, 32'd0);
        check("abort_type3", {29'd0, tlb_type}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlb_op_ctrl.md
# tlb_op_ctrl

Sequencer for TLB maintenance instructions (TLBP, TLBR, TLBWI, TLBWR), placed between the MEM stage and the TLB array, with CP0 alongside. It accepts one TLB op at a time and drives the TLB op-type input for exactly one cycle. It captures the TLB's combinational results into holding registers, then issues one-cycle CP0 write enables. It owns the Random and Wired registers and supplies the write slot for TLBWR.

## Interface
Parameters:
- TLB_LINE, 32, number of TLB entries
- TLB_WIDTH, 5, index width, clog2(TLB_LINE)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  MEM stage presents a TLB op
- req_op  in  3  op code: 3'b001 TLBP, 3'b010 TLBR, 3'b011 TLBWI, 3'b100 TLBWR; any other value is a no-op
- req_ready  out  1  high only in IDLE
- flush  in  1  pipeline exception flush
- stall  out  1  hold the pipeline
- done  out  1  one-cycle completion pulse
- refetch  out  1  valid with done; 1 for TLBWI/TLBWR
- tlb_type  out  3  op code to the TLB; 0 when idle
- tlb_random  out  32  Random value sent to the TLB, zero-extended
- tlb_index_in  in  32  Index result from the TLB (TLBP)
- tlb_entryhi_in, tlb_pagemask_in, tlb_entrylo0_in, tlb_entrylo1_in  in  32 each  TLBR results
- cp0_index_we  out  1  write CP0 Index
- cp0_index_wdata  out  32  captured Index value
- cp0_tlbr_we  out  1  write CP0 EntryHi, PageMask, EntryLo0 and EntryLo1
- cp0_entryhi_wdata, cp0_pagemask_wdata, cp0_entrylo0_wdata, cp0_entrylo1_wdata  out  32 each
- wired_we  in  1  CP0 write to Wired
- wired_wdata  in  TLB_WIDTH  new Wired value
- random_o  out  TLB_WIDTH  current Random, for CP0 reads
- wired_o  out  TLB_WIDTH  current Wired

## Operation
- FSM states: IDLE, ISSUE, COMMIT.
- IDLE:
  - Accept when req_valid & ~flush & req_op is a valid code.
  - On accept: latch op into op_q, latch random_o into rnd_q, go to ISSUE.
  - A no-op code, or req_valid together with flush, is dropped; the FSM stays in IDLE.
- ISSUE:
  - tlb_type = op_q; tlb_random = rnd_q.
  - Capture the TLB outputs: tlb_index_in into idx_q when op_q is TLBP; the four TLBR inputs into the hold registers when op_q is TLBR.
  - Go to COMMIT.
- COMMIT:
  - done = 1.
  - cp0_index_we = (op_q == TLBP); cp0_tlbr_we = (op_q == TLBR).
  - refetch = op_q is TLBWI or TLBWR.
  - tlb_type = 0. Go to IDLE.
- flush in ISSUE or COMMIT is ignored. An accepted op always completes.
- stall = (IDLE & req_valid & valid op & ~flush) | ISSUE. stall is 0 in COMMIT, so the pipeline advances on the done cycle.
- cp0_*_wdata are driven continuously from the hold registers.
- Random / Wired:
  - Each cycle: if random_o == wired_o, reload to TLB_LINE-1; otherwise decrement.
  - wired_we: Wired <= wired_wdata and Random <= TLB_LINE-1. This has priority over decrement and reload.
  - With Wired = TLB_LINE-1, Random stays at TLB_LINE-1.
  - Random runs in every state. TLBWR uses rnd_q, so a change to Random after acceptance does not move the write slot.

## Timing
- Reset values:
  - state IDLE; Random TLB_LINE-1; Wired 0; all hold registers 0.
  - tlb_type 0, done 0, refetch 0, cp0_index_we 0, cp0_tlbr_we 0, stall 0, req_ready 1.
- Latency: accept at cycle T, tlb_type valid at T+1, done and CP0 write enables at T+2. Next acceptance no earlier than T+3.
- The TLB is combinational and writes on the edge that closes ISSUE. No TLB op is active in COMMIT.
- rst mid-op aborts immediately to IDLE. No done pulse and no CP0 write enable follow.
- tlb_type is nonzero in exactly one cycle per op.

## Test plan
- Reset, then 40 idle cycles with Wired = 0 -> random_o goes 31, 30, …, 0, 31. Outputs match the reset values listed above.
- wired_we = 1 with wired_wdata = 8 while Random = 3 -> Random = 31 the next cycle, then counts down to 8 and reloads to 31; it never drops below 8.
- TLBP accepted at T with tlb_index_in = 0x0000_0005 at T+1 -> tlb_type = 3'b001 at T+1; cp0_index_we = 1 and cp0_index_wdata = 5 at T+2. stall is high at T and T+1, low at T+2. Repeat with tlb_index_in = 0x8000_0000; cp0_index_wdata = 0x8000_0000.
- TLBR with TLBR inputs 0x1234_5000, 0x0000_6000, 0x0000_0217, 0x0000_0257 -> at T+2, cp0_tlbr_we = 1 with those four values and done = 1.
- TLBWR accepted when Random = 20, with wired_we at T+1 -> tlb_random = 20 at T+1. done = 1 and refetch = 1 at T+2.
- req_valid with flush in IDLE -> no accept and no stall. flush at T+1 of a TLBWI -> the op completes with done at T+2. rst at T+1 -> tlb_type = 0 and done never asserted.
